lpm_pipe: RTL and testbench

- Parametrised longest-prefix-match lookup engine; successor to the fixed 32-bit / 16-ticket LPM block.
- Walks a multibit trie in external memory, STRIDE key bits per level, recirculating each lookup until it hits a leaf or runs out of levels.
- Multiple lookups are in flight at once; responses may complete out of order.
- A ticketed completion buffer restores request order before results are enqueued on outQ.

---
 rtl/lpm_pipe_if.sv | 42 ++++
 rtl/lpm_pipe.sv | 178 +++++++++++++++++
 tb/tb_lpm_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpm_pipe_if.sv
// Handshake bundle of the LPM engine: key requests, trie-memory reads and the result queue.
// The master modport is the engine side; the slave modport is the environment side.
interface lpm_pipe_if #(
  parameter int KEY_W  = 32,
  parameter int ADDR_W = 32,
  parameter int RES_W  = 32
);
  logic              requestEnterEna;
  logic [KEY_W-1:0]  requestEnterX;
  logic              requestEnterRdy;

  logic              memReqEna;
  logic [ADDR_W-1:0] memReqV;
  logic              memReqRdy;
  logic [RES_W-1:0]  memResValue;
  logic              memResValueRdy;
  logic              memResAcceptEna;

  logic              outQEnqEna;
  logic [RES_W-1:0]  outQEnqV;
  logic              outQEnqRdy;

  modport master (
    input  requestEnterEna, requestEnterX,
    output requestEnterRdy,
    output memReqEna, memReqV,
    input  memReqRdy, memResValue, memResValueRdy,
    output memResAcceptEna,
    output outQEnqEna, outQEnqV,
    input  outQEnqRdy
  );

  modport slave (
    output requestEnterEna, requestEnterX,
    input  requestEnterRdy,
    input  memReqEna, memReqV,
    output memReqRdy, memResValue, memResValueRdy,
    input  memResAcceptEna,
    input  outQEnqEna, outQEnqV,
    output outQEnqRdy
  );
endinterface

// File: rtl/lpm_pipe.sv
// Pipelined longest-prefix-match engine: multibit trie walk with recirculation and in-order completion.
// Optional lookup/recirculation counters are built when LPM_STATS_EN is defined.
module lpm_pipe #(
  parameter int                KEY_W     = 32,
  parameter int                STRIDE    = 8,
  parameter int                ADDR_W    = 32,
  parameter int                RES_W     = 32,
  parameter int                TAG_W     = 4,
  parameter logic [ADDR_W-1:0] ROOT_BASE = '0
) (
  input  logic        CLK,
  input  logic        RST,
  lpm_pipe_if.master  bus
`ifdef LPM_STATS_EN
  ,
  output logic [31:0] statsLookups,
  output logic [31:0] statsRecircs
`endif
);

  localparam int               LEVELS    = KEY_W / STRIDE;
  localparam int               LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int               DEPTH     = 1 << TAG_W;
  localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(LEVELS - 1);
  localparam logic [RES_W-1:0] MISS      = '1;

  function automatic logic [ADDR_W-1:0] chunkOf(input logic [KEY_W-1:0] key, input int n);
    logic [KEY_W-1:0] sh;
    sh = key << (n * STRIDE);
    return ADDR_W'(sh[KEY_W-1 -: STRIDE]);
  endfunction

  logic                 r_inValid;
  logic [KEY_W-1:0]     r_inKey;
  logic [TAG_W-1:0]     r_inTicket;
  logic [TAG_W:0]       r_head;
  logic [TAG_W:0]       r_tail;
  logic [TAG_W:0]       r_ctxWr;
  logic [TAG_W:0]       r_ctxRd;
  logic [LVL_W-1:0]     r_ctxLevel  [DEPTH];
  logic [KEY_W-1:0]     r_ctxKey    [DEPTH];
  logic [TAG_W-1:0]     r_ctxTicket [DEPTH];
  logic [DEPTH-1:0]     r_slotValid;
  logic [RES_W-1:0]     r_slotData  [DEPTH];

  logic [TAG_W:0]       w_inUse;
  logic [TAG_W:0]       w_ctxCount;
  logic                 w_ctxEmpty;
  logic                 w_ctxFull;
  logic [TAG_W-1:0]     w_rdIdx;
  logic [TAG_W-1:0]     w_wrIdx;
  logic [TAG_W-1:0]     w_headIdx;
  logic [LVL_W-1:0]     w_hdLevel;
  logic [KEY_W-1:0]     w_hdKey;
  logic [TAG_W-1:0]     w_hdTicket;
  logic                 w_resPresent;
  logic                 w_isLeaf;
  logic                 w_orphan;
  logic                 w_matched;
  logic                 w_terminate;
  logic                 w_wantRecirc;
  logic                 w_recirc;
  logic                 w_newIssue;
  logic                 w_enterRdy;
  logic                 w_accept;
  logic                 w_enq;
  logic                 w_ctxPush;
  logic                 w_ctxPop;
  logic [LVL_W-1:0]     w_pushLevel;
  logic [KEY_W-1:0]     w_pushKey;
  logic [TAG_W-1:0]     w_pushTicket;

  assign w_inUse      = r_tail - r_head;
  assign w_ctxCount   = r_ctxWr - r_ctxRd;
  assign w_ctxEmpty   = (w_ctxCount == '0);
  assign w_ctxFull    = (w_ctxCount == DEPTH_CNT);
  assign w_rdIdx      = r_ctxRd[TAG_W-1:0];
  assign w_wrIdx      = r_ctxWr[TAG_W-1:0];
  assign w_headIdx    = r_head[TAG_W-1:0];
  assign w_hdLevel    = r_ctxLevel[w_rdIdx];
  assign w_hdKey      = r_ctxKey[w_rdIdx];
  assign w_hdTicket   = r_ctxTicket[w_rdIdx];

  assign w_resPresent = bus.memResValueRdy && !RST;
  assign w_isLeaf     = bus.memResValue[RES_W-1];
  assign w_orphan     = w_resPresent && w_ctxEmpty;
  assign w_matched    = w_resPresent && !w_ctxEmpty;
  assign w_terminate  = w_matched && (w_isLeaf || (w_hdLevel == LAST_LVL));
  assign w_wantRecirc = w_matched && !w_terminate;
  // A recirculation pops the context FIFO as it pushes, so a full FIFO must not block it.
  assign w_recirc     = w_wantRecirc && bus.memReqRdy;
  assign w_newIssue   = r_inValid && !w_wantRecirc && bus.memReqRdy && !w_ctxFull && !RST;

  assign w_enterRdy   = !RST && !r_inValid && (w_inUse < DEPTH_CNT);
  assign w_accept     = bus.requestEnterEna && w_enterRdy;
  assign w_enq        = r_slotValid[w_headIdx] && bus.outQEnqRdy && !RST;

  assign w_ctxPush    = w_recirc || w_newIssue;
  assign w_ctxPop     = w_terminate || w_recirc;
  assign w_pushLevel  = w_recirc ? (w_hdLevel + LVL_W'(1)) : '0;
  assign w_pushKey    = w_recirc ? w_hdKey : r_inKey;
  assign w_pushTicket = w_recirc ? w_hdTicket : r_inTicket;

  always_comb begin
    bus.requestEnterRdy = w_enterRdy;
    bus.memReqEna       = w_recirc || w_newIssue;
    bus.memReqV         = '0;
    if (w_recirc) begin
      bus.memReqV = bus.memResValue[ADDR_W-1:0] + chunkOf(w_hdKey, int'(w_hdLevel) + 1);
    end else if (w_newIssue) begin
      bus.memReqV = ROOT_BASE + chunkOf(r_inKey, 0);
    end
    bus.memResAcceptEna = w_terminate || w_recirc || w_orphan;
    bus.outQEnqEna      = w_enq;
    bus.outQEnqV        = w_enq ? r_slotData[w_headIdx] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inValid   <= 1'b0;
      r_inKey     <= '0;
      r_inTicket  <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_ctxWr     <= '0;
      r_ctxRd     <= '0;
      r_slotValid <= '0;
    end else begin
      if (w_accept) begin
        r_inValid  <= 1'b1;
        r_inKey    <= bus.requestEnterX;
        r_inTicket <= r_tail[TAG_W-1:0];
        r_tail     <= r_tail + 1'b1;
      end else if (w_newIssue) begin
        r_inValid <= 1'b0;
      end
      if (w_ctxPush) r_ctxWr <= r_ctxWr + 1'b1;
      if (w_ctxPop)  r_ctxRd <= r_ctxRd + 1'b1;
      if (w_enq) begin
        r_slotValid[w_headIdx] <= 1'b0;
        r_head                 <= r_head + 1'b1;
      end
      if (w_terminate) r_slotValid[w_hdTicket] <= 1'b1;
    end
  end

  // Payload storage needs no reset: the pointers and valid bits alone decide what is live.
  always_ff @(posedge CLK) begin
    if (w_ctxPush) begin
      r_ctxLevel[w_wrIdx]  <= w_pushLevel;
      r_ctxKey[w_wrIdx]    <= w_pushKey;
      r_ctxTicket[w_wrIdx] <= w_pushTicket;
    end
    if (w_terminate) begin
      r_slotData[w_hdTicket] <= w_isLeaf ? {1'b0, bus.memResValue[RES_W-2:0]} : MISS;
    end
  end

`ifdef LPM_STATS_EN
  logic [31:0] r_lookups;
  logic [31:0] r_recircs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lookups <= '0;
      r_recircs <= '0;
    end else begin
      if (w_accept && (r_lookups != '1)) r_lookups <= r_lookups + 32'd1;
      if (w_recirc && (r_recircs != '1)) r_recircs <= r_recircs + 32'd1;
    end
  end

  assign statsLookups = r_lookups;
  assign statsRecircs = r_recircs;
`endif

endmodule

// File: tb/tb_lpm_pipe.sv
// Directed bench for lpm_pipe: a trie-memory model with configurable latency feeds the engine,
// and every result and memory address is compared against hand-computed values.
module tb_lpm_pipe;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  lpm_pipe_if #(.KEY_W(32), .ADDR_W(32), .RES_W(32)) bus();

`ifdef LPM_STATS_EN
  logic [31:0] statsLookups;
  logic [31:0] statsRecircs;
`endif

  lpm_pipe #(
    .KEY_W(32), .STRIDE(8), .ADDR_W(32), .RES_W(32), .TAG_W(4), .ROOT_BASE(32'h0)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
`ifdef LPM_STATS_EN
    ,
    .statsLookups (statsLookups),
    .statsRecircs (statsRecircs)
`endif
  );

  logic [31:0] memTable [logic [31:0]];
  pend_t       pending [$];
  logic [31:0] reqLog [$];
  logic [31:0] outLog [$];
  int          cycle = 0;
  int          memLat = 1;
  int          assertCount = 0;
  int          failCount = 0;

  logic        sAccept;
  logic        sReq;
  logic [31:0] sAddr;
  logic        sEnq;
  logic [31:0] sOut;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memTable.exists(a)) return memTable[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] outAt(input int i);
    if (i < outLog.size()) return outLog[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] reqAt(input int i);
    if (i < reqLog.size()) return reqLog[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Memory and result-queue model: sample on the falling edge, act just after the rising edge.
  initial begin
    bus.memReqRdy      = 1'b1;
    bus.memResValueRdy = 1'b0;
    bus.memResValue    = 32'h0;
    forever begin
      @(negedge CLK);
      sAccept = bus.memResAcceptEna;
      sReq    = bus.memReqEna && bus.memReqRdy;
      sAddr   = bus.memReqV;
      sEnq    = bus.outQEnqEna;
      sOut    = bus.outQEnqV;
      @(posedge CLK);
      cycle++;
      #1;
      if (sAccept && pending.size() > 0) void'(pending.pop_front());
      if (sReq) begin
        pend_t p;
        reqLog.push_back(sAddr);
        p.data = memRead(sAddr);
        p.due  = cycle + memLat - 1;
        pending.push_back(p);
      end
      if (sEnq) outLog.push_back(sOut);
      if (pending.size() > 0 && pending[0].due <= cycle) begin
        bus.memResValueRdy = 1'b1;
        bus.memResValue    = pending[0].data;
      end else begin
        bus.memResValueRdy = 1'b0;
        bus.memResValue    = 32'h0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] key, input int maxCycles, output bit ok);
    ok = 1'b0;
    bus.requestEnterEna = 1'b1;
    bus.requestEnterX   = key;
    for (int i = 0; i < maxCycles && !ok; i++) begin
      @(negedge CLK);
      if (bus.requestEnterRdy) ok = 1'b1;
      @(posedge CLK);
      #2;
    end
    bus.requestEnterEna = 1'b0;
  endtask

  task automatic waitResults(input string tag, input int n, input int maxCycles);
    for (int i = 0; i < maxCycles && outLog.size() < n; i++) stepCycles(1);
    checkOutput(tag, 32'(outLog.size()), 32'(n));
  endtask

  task automatic clearLogs();
    reqLog.delete();
    outLog.delete();
  endtask

  initial begin
    bit          ok;
    int          accepted;
`ifdef LPM_STATS_EN
    logic [31:0] recircBase;
`endif
    bus.requestEnterEna = 1'b0;
    bus.requestEnterX   = 32'h0;
    bus.outQEnqRdy      = 1'b1;

    // Reset state
    stepCycles(3);
    @(negedge CLK);
    checkOutput("rst_mem_ena", 32'(bus.memReqEna), 32'h0);
    checkOutput("rst_acc_ena", 32'(bus.memResAcceptEna), 32'h0);
    checkOutput("rst_outq_ena", 32'(bus.outQEnqEna), 32'h0);
    @(posedge CLK); #2;
    RST = 1'b0;
    stepCycles(1);
    @(negedge CLK);
    checkOutput("idle_enter_rdy", 32'(bus.requestEnterRdy), 32'h1);
    checkOutput("idle_mem_addr", bus.memReqV, 32'h0);
    checkOutput("idle_outq_v", bus.outQEnqV, 32'h0);
    @(posedge CLK); #2;

    // Single-level leaf lookup
    memTable.delete();
    memTable[32'h0A] = 32'h8000_0055;
    clearLogs();
    applyStimulus(32'h0A00_0001, 10, ok);
    checkOutput("t1_accept", 32'(ok), 32'h1);
    waitResults("t1_count", 1, 50);
    stepCycles(5);
    checkOutput("t1_nreq", 32'(reqLog.size()), 32'd1);
    checkOutput("t1_addr0", reqAt(0), 32'h0000_000A);
    checkOutput("t1_result", outAt(0), 32'h0000_0055);

    // Two-level walk
    memTable.delete();
    memTable[32'h0A]  = 32'h0000_0100;
    memTable[32'h101] = 32'h8000_0077;
    clearLogs();
`ifdef LPM_STATS_EN
    recircBase = statsRecircs;
`endif
    applyStimulus(32'h0A01_0000, 10, ok);
    waitResults("t2_count", 1, 50);
    stepCycles(5);
    checkOutput("t2_nreq", 32'(reqLog.size()), 32'd2);
    checkOutput("t2_addr0", reqAt(0), 32'h0000_000A);
    checkOutput("t2_addr1", reqAt(1), 32'h0000_0101);
    checkOutput("t2_result", outAt(0), 32'h0000_0077);
`ifdef LPM_STATS_EN
    checkOutput("t2_recircs", statsRecircs - recircBase, 32'd1);
`endif

    // Out-of-order completion restored to request order
    memLat = 2;
    memTable.delete();
    memTable[32'h01]  = 32'h0000_0200;
    memTable[32'h202] = 32'h0000_0300;
    memTable[32'h303] = 32'h0000_0400;
    memTable[32'h404] = 32'h8000_00AA;
    memTable[32'h05]  = 32'h8000_00BB;
    clearLogs();
    applyStimulus(32'h0102_0304, 10, ok);
    applyStimulus(32'h0500_0000, 10, ok);
    waitResults("t3_count", 2, 100);
    stepCycles(5);
    checkOutput("t3_nreq", 32'(reqLog.size()), 32'd5);
    checkOutput("t3_first", outAt(0), 32'h0000_00AA);
    checkOutput("t3_second", outAt(1), 32'h0000_00BB);

    // Miss after walking every level
    memLat = 1;
    memTable.delete();
    clearLogs();
    applyStimulus(32'hFFFF_FFFF, 10, ok);
    waitResults("t4_count", 1, 50);
    stepCycles(5);
    checkOutput("t4_nreq", 32'(reqLog.size()), 32'd4);
    checkOutput("t4_addr3", reqAt(3), 32'h0000_00FF);
    checkOutput("t4_result", outAt(0), 32'hFFFF_FFFF);

    // Ticket exhaustion under result backpressure
    memTable.delete();
    for (int i = 0; i <= 16; i++) memTable[32'(8'h10 + i)] = 32'h8000_0000 | 32'(12'h100 + i);
    clearLogs();
    bus.outQEnqRdy = 1'b0;
    accepted = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus({8'(8'h10 + i), 24'h0}, 20, ok);
      if (ok) accepted++;
    end
    checkOutput("t5_accepted", 32'(accepted), 32'd16);
    stepCycles(30);
    @(negedge CLK);
    checkOutput("t5_full_rdy", 32'(bus.requestEnterRdy), 32'h0);
    checkOutput("t5_held", 32'(outLog.size()), 32'd0);
    @(posedge CLK); #2;
    applyStimulus(32'h2000_0000, 20, ok);
    checkOutput("t5_17th_blocked", 32'(ok), 32'h0);
    bus.outQEnqRdy = 1'b1;
    waitResults("t5_drain", 16, 200);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("t5_res%0d", i), outAt(i), 32'(12'h100 + i));
    applyStimulus(32'h2000_0000, 20, ok);
    checkOutput("t5_17th_accept", 32'(ok), 32'h1);
    waitResults("t5_17th_count", 17, 50);
    checkOutput("t5_17th_result", outAt(16), 32'h0000_0110);

    // Reset with lookups in flight
    memLat = 4;
    memTable.delete();
    clearLogs();
    applyStimulus(32'h1111_1111, 10, ok);
    applyStimulus(32'h2222_2222, 10, ok);
    applyStimulus(32'h3333_3333, 10, ok);
    stepCycles(2);
    RST = 1'b1;
    stepCycles(1);
    @(negedge CLK);
    checkOutput("t6_rst_mem_ena", 32'(bus.memReqEna), 32'h0);
    checkOutput("t6_rst_acc_ena", 32'(bus.memResAcceptEna), 32'h0);
    @(posedge CLK); #2;
    RST = 1'b0;
    outLog.delete();
    stepCycles(30);
    checkOutput("t6_no_enq", 32'(outLog.size()), 32'd0);
    checkOutput("t6_stale_drained", 32'(pending.size()), 32'd0);
    memTable[32'h0A] = 32'h8000_0055;
    clearLogs();
    applyStimulus(32'h0A00_0001, 10, ok);
    waitResults("t6_count", 1, 50);
    checkOutput("t6_result", outAt(0), 32'h0000_0055);
    checkOutput("t6_addr0", reqAt(0), 32'h0000_000A);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
